// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the MEM-stage load/store controller.
//   DATA_W      datapath width (only 32 is supported)
//   state_t     controller FSM states (IDLE, RD, WR, RESP)
//   SZ_*        request size codes; 2'b11 is reserved and behaves as a word
//   is_word     true for word and reserved size codes
//   misaligned  natural-alignment test used when MEM_ACCESS_ALIGN_CHECK_EN is defined
package mem_access_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Bit 1 set covers both SZ_WORD and the reserved code 2'b11.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      if (size[1]) begin
         bad = (lane != 2'b00);
      end else if (size == SZ_HALF) begin
         bad = lane[0];
      end
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for mem_access_ctrl
// (little-endian lane order).
// Ports:
//   buf_i     word previously read from memory (read-modify-write source)
//   wdata_i   right-justified store data
//   rword_i   word read from memory for load extraction
//   size_i    access size code (SZ_BYTE / SZ_HALF / word)
//   lane_i    byte address bits [1:0]
//   sign_i    sign-extend sub-word load results
//   merged_o  store word: selected lane(s) replaced by wdata, rest from buf_i
//   rdata_o   load result: selected lane(s), zero- or sign-extended
// Halfword accesses use lane_i[1] only; word accesses ignore lane_i.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [DATA_W-1:0] buf_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rword_i,
   input  logic [1:0]        size_i,
   input  logic [1:0]        lane_i,
   input  logic              sign_i,
   output logic [DATA_W-1:0] merged_o,
   output logic [DATA_W-1:0] rdata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      merged_o = buf_i;
      case (size_i)
         SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
         SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         default: merged_o = wdata_i;
      endcase
   end

   always_comb begin
      byte_v  = rword_i[{lane_i, 3'b000} +: 8];
      half_v  = rword_i[{lane_i[1], 4'b0000} +: 16];
      case (size_i)
         SZ_BYTE: rdata_o = {{(DATA_W-8){sign_i & byte_v[7]}}, byte_v};
         SZ_HALF: rdata_o = {{(DATA_W-16){sign_i & half_v[15]}}, half_v};
         default: rdata_o = rword_i;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator for a word-wide data memory.
// Accepts one byte/half/word request at a time (valid/ready); sub-word stores
// are done as read-modify-write, sub-word loads are lane-extracted and extended.
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake (ready only in IDLE, out of reset)
//   req_we, req_size,
//   req_sign, req_addr,
//   req_wdata                 request fields, latched on accept
//   resp_valid                one-cycle completion pulse (no backpressure)
//   resp_rdata                load result, 0 for stores and errors
//   resp_err                  misaligned access flag
//   mem_we, mem_addr,
//   mem_wdata, mem_rdata      word memory port; mem_addr is a word index
// Build option: define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with resp_err; otherwise resp_err is always 0 and low address bits
// are ignored for those sizes.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int unsigned DATA_W = mem_access_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_sign,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state_q, state_d;
   logic [31:0]       addr_q;
   logic [1:0]        size_q;
   logic              sign_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] buf_q;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   logic              accept;
   logic              misalign;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] ld_result;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   assign misalign = misaligned(req_size, req_addr[1:0]);
`else
   assign misalign = 1'b0;
`endif

   assign req_ready = (state_q == ST_IDLE) && clrn;
   assign accept    = req_valid && req_ready;

   mem_lane_align u_align (
      .buf_i    (buf_q),
      .wdata_i  (wdata_q),
      .rword_i  (mem_rdata),
      .size_i   (size_q),
      .lane_i   (addr_q[1:0]),
      .sign_i   (sign_q),
      .merged_o (merged),
      .rdata_o  (ld_result)
   );

   always_comb begin
      state_d      = state_q;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (misalign) begin
                  state_d    = ST_RESP;
                  resp_err_d = 1'b1;
               end else if (req_we && is_word(req_size)) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (we_q) begin
               state_d = ST_WR;
            end else begin
               // Load result is taken straight from the read data of this cycle.
               state_d      = ST_RESP;
               resp_rdata_d = ld_result;
            end
         end
         ST_WR:   state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         size_q       <= SZ_BYTE;
         sign_q       <= 1'b0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         buf_q        <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            sign_q  <= req_sign;
            we_q    <= req_we;
            wdata_q <= req_wdata;
         end
         if (state_q == ST_RD) begin
            buf_q <= mem_rdata;
         end
      end
   end

   // Memory-side outputs decode directly from the state register, so an
   // asynchronous reset removes mem_we and mem_addr in the same instant.
   assign mem_we     = (state_q == ST_WR);
   assign mem_wdata  = (state_q == ST_WR) ? merged : '0;
   assign mem_addr   = (state_q == ST_IDLE) ? 32'd0 : {2'b00, addr_q[31:2]};
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
